// File: rtl/hash_pkg.sv
// Shared constants for the SHA-256 header padder and its receive-side checker.
package hash_pkg;

    localparam int HDR_WORDS = 20;
    localparam int BLK_WORDS = 32;
    localparam int SEP_IDX   = 20;
    localparam int LEN_IDX   = 31;
    localparam int CNT_W     = 5;

    localparam logic [31:0] SEP_WORD = 32'h8000_0000;
    localparam logic [31:0] LEN_WORD = 32'h0000_0280;

    typedef enum logic {
        ST_COLLECT,
        ST_HOLD
    } depad_state_e;

endpackage

// File: rtl/pad_word_check.sv
// Flags a padding word that does not match what its block position requires.
module pad_word_check
    import hash_pkg::*;
(
    input  logic [CNT_W-1:0] cnt_i,
    input  logic [31:0]      word_i,
    output logic             sep_mis_o,
    output logic             zero_mis_o,
    output logic             len_mis_o
);

    logic is_sep;
    logic is_zero;
    logic is_len;

    always_comb begin
        is_sep     = (cnt_i == CNT_W'(SEP_IDX));
        is_len     = (cnt_i == CNT_W'(LEN_IDX));
        is_zero    = (cnt_i > CNT_W'(SEP_IDX)) && (cnt_i < CNT_W'(LEN_IDX));
        sep_mis_o  = is_sep && (word_i != SEP_WORD);
        zero_mis_o = is_zero && (word_i != '0);
        len_mis_o  = is_len && (word_i != LEN_WORD);
    end

endmodule

// File: rtl/hash_depad.sv
// Reassembles the 640-bit header from a padded 1024-bit block stream
// and reports separator, zero-fill, length and framing errors.
module hash_depad #(
    parameter int DATA_W    = 32,
    parameter int HDR_W     = 640,
    parameter int BLK_WORDS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [HDR_W-1:0]  header_out,
    output logic              hdr_valid,
    input  logic              hdr_ready,
    output logic              sep_err,
    output logic              zero_err,
    output logic              len_err,
    output logic              frame_err
);

    import hash_pkg::*;

    depad_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [HDR_W-1:0] hdr_q, hdr_d;
    logic             sep_q, sep_d;
    logic             zero_q, zero_d;
    logic             len_q, len_d;
    logic             frame_q, frame_d;

    logic acc;
    logic at_end;
    logic sep_mis, zero_mis, len_mis;

    pad_word_check u_chk (
        .cnt_i      (cnt_q),
        .word_i     (in_data),
        .sep_mis_o  (sep_mis),
        .zero_mis_o (zero_mis),
        .len_mis_o  (len_mis)
    );

    assign in_ready   = (state_q == ST_COLLECT);
    assign hdr_valid  = (state_q == ST_HOLD);
    assign header_out = hdr_q;
    assign sep_err    = sep_q;
    assign zero_err   = zero_q;
    assign len_err    = len_q;
    assign frame_err  = frame_q;

    assign acc    = in_valid && in_ready;
    assign at_end = (cnt_q == CNT_W'(BLK_WORDS - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hdr_d   = hdr_q;
        sep_d   = sep_q;
        zero_d  = zero_q;
        len_d   = len_q;
        frame_d = frame_q;
        unique case (state_q)
            ST_COLLECT: begin
                if (acc) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    for (int i = 0; i < HDR_W / DATA_W; i++) begin
                        if (cnt_q == CNT_W'(i))
                            hdr_d[HDR_W-1-DATA_W*i -: DATA_W] = in_data;
                    end
                    sep_d  = sep_q | sep_mis;
                    zero_d = zero_q | zero_mis;
                    len_d  = len_q | len_mis;
                    // Early last or missing last on the final word is a framing fault.
                    if (in_last || at_end) begin
                        state_d = ST_HOLD;
                        cnt_d   = '0;
                        frame_d = frame_q | (in_last != at_end);
                    end
                end
            end
            ST_HOLD: begin
                if (hdr_ready) begin
                    state_d = ST_COLLECT;
                    sep_d   = 1'b0;
                    zero_d  = 1'b0;
                    len_d   = 1'b0;
                    frame_d = 1'b0;
                end
            end
            default: state_d = ST_COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_COLLECT;
            cnt_q   <= '0;
            hdr_q   <= '0;
            sep_q   <= 1'b0;
            zero_q  <= 1'b0;
            len_q   <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hdr_q   <= hdr_d;
            sep_q   <= sep_d;
            zero_q  <= zero_d;
            len_q   <= len_d;
            frame_q <= frame_d;
        end
    end

endmodule
